touch_dir_decoder: RTL and testbench

Clocked, parametrised touch-to-direction decoder that follows the combinational touch-zone LED decoder. Classifies each touch coordinate sample against N_ZONES runtime-programmable rectangles. Debounces the zone over DEBOUNCE_N consecutive samples and emits a level direction vector. Adds a press pulse with hold-to-repeat, for the LED/game controller downstream of the touch-panel sampler.

---
 rtl/touch_pkg.sv | 14 +
 rtl/touch_zone_match.sv | 32 +++
 rtl/touch_dir_decoder.sv | 125 ++++++++++++
 tb/tb_touch_dir_decoder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// touch_pkg: shared state encoding and default zone map for the 240x240 touch panel.
package touch_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} state_t;

    localparam int TOUCH_COORD_W = 8;

    // Exclusive bounds, zone3 in the top byte: {left, down, up, right}
    localparam logic [4*TOUCH_COORD_W-1:0] ZONE_XLO = {8'd69,  8'd26,  8'd223, 8'd69};
    localparam logic [4*TOUCH_COORD_W-1:0] ZONE_XHI = {8'd142, 8'd43,  8'd240, 8'd142};
    localparam logic [4*TOUCH_COORD_W-1:0] ZONE_YLO = {8'd211, 8'd74,  8'd74,  8'd13};
    localparam logic [4*TOUCH_COORD_W-1:0] ZONE_YHI = {8'd240, 8'd153, 8'd153, 8'd31};

endpackage

// File: rtl/touch_zone_match.sv
// touch_zone_match: strict rectangle compare against every zone, lowest matching index wins.
module touch_zone_match #(
    parameter int COORD_W = 8,
    parameter int N_ZONES = 4,
    localparam int IDX_W  = N_ZONES > 1 ? $clog2(N_ZONES) : 1
) (
    input  logic [COORD_W-1:0]         i_x,
    input  logic [COORD_W-1:0]         i_y,
    input  logic [N_ZONES*COORD_W-1:0] i_xlo,
    input  logic [N_ZONES*COORD_W-1:0] i_xhi,
    input  logic [N_ZONES*COORD_W-1:0] i_ylo,
    input  logic [N_ZONES*COORD_W-1:0] i_yhi,
    output logic                       o_hit,
    output logic [IDX_W-1:0]           o_idx
);

    logic [N_ZONES-1:0] w_m;

    for (genvar g = 0; g < N_ZONES; g++) begin : g_cmp
        assign w_m[g] = (i_xlo[g*COORD_W +: COORD_W] < i_x) && (i_x < i_xhi[g*COORD_W +: COORD_W]) &&
                        (i_ylo[g*COORD_W +: COORD_W] < i_y) && (i_y < i_yhi[g*COORD_W +: COORD_W]);
    end

    assign o_hit = |w_m;

    always_comb begin
        o_idx = '0;
        for (int i = N_ZONES - 1; i >= 0; i--)
            if (w_m[i]) o_idx = IDX_W'(i);
    end

endmodule

// File: rtl/touch_dir_decoder.sv
// touch_dir_decoder: debounced touch-zone direction level plus press pulse with hold-to-repeat.
module touch_dir_decoder
    import touch_pkg::*;
#(
    parameter int COORD_W    = TOUCH_COORD_W,
    parameter int N_ZONES    = 4,
    parameter int DEBOUNCE_N = 3,
    parameter int REPEAT_DLY = 5000000,
    parameter int REPEAT_PER = 1000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pen_down,
    input  logic                       sample_vld,
    input  logic [COORD_W-1:0]         x_in,
    input  logic [COORD_W-1:0]         y_in,
    input  logic [N_ZONES*COORD_W-1:0] zone_xlo,
    input  logic [N_ZONES*COORD_W-1:0] zone_xhi,
    input  logic [N_ZONES*COORD_W-1:0] zone_ylo,
    input  logic [N_ZONES*COORD_W-1:0] zone_yhi,
    output logic [N_ZONES-1:0]         dir,
    output logic [N_ZONES-1:0]         dir_pulse,
    output logic                       busy
);

    localparam int IDX_W   = N_ZONES > 1 ? $clog2(N_ZONES) : 1;
    localparam int CNT_W   = $clog2(DEBOUNCE_N + 1);
    localparam int TMR_LIM = REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER;
    localparam int TMR_W   = $clog2(TMR_LIM + 1);
    localparam logic [TMR_W-1:0] DLY_END = TMR_W'(REPEAT_DLY > 0 ? REPEAT_DLY - 1 : 0);
    localparam logic [TMR_W-1:0] PER_END = TMR_W'(REPEAT_PER - 1);
    localparam logic [TMR_W-1:0] TMR_TOP = TMR_W'(TMR_LIM);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEBOUNCE_N);

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_cand, w_cand, w_idx;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [TMR_W-1:0]   r_tmr, w_tmr;
    logic [N_ZONES-1:0] r_dir, w_dir, r_pulse, w_pulse;
    logic               r_busy, w_hit, w_same, w_expire;

    touch_zone_match #(.COORD_W(COORD_W), .N_ZONES(N_ZONES)) u_match (
        .i_x(x_in), .i_y(y_in),
        .i_xlo(zone_xlo), .i_xhi(zone_xhi), .i_ylo(zone_ylo), .i_yhi(zone_yhi),
        .o_hit(w_hit), .o_idx(w_idx)
    );

    assign w_same   = w_hit && (w_idx == r_cand);
    assign w_expire = (r_state == HELD && REPEAT_DLY != 0 && r_tmr == DLY_END) ||
                      (r_state == REPEAT && r_tmr == PER_END);

    always_comb begin
        w_state = r_state;
        w_cand  = r_cand;
        w_cnt   = r_cnt;
        w_tmr   = r_tmr;
        w_dir   = r_dir;
        w_pulse = '0;
        if (!pen_down) begin
            w_state = IDLE;
            w_cand  = '0;
            w_cnt   = '0;
            w_tmr   = '0;
            w_dir   = '0;
        end else begin
            case (r_state)
                IDLE: if (sample_vld && w_hit) begin
                    w_state = DEBOUNCE;
                    w_cand  = w_idx;
                    w_cnt   = CNT_W'(1);
                end
                DEBOUNCE: if (sample_vld) begin
                    w_state = w_hit ? DEBOUNCE : IDLE;
                    w_cand  = w_hit ? w_idx : r_cand;
                    w_cnt   = !w_hit ? '0 : w_same ? r_cnt + CNT_W'(1) : CNT_W'(1);
                end
                default: if (sample_vld && !w_same) begin
                    // Leaving the held zone always drops dir; a new hit restarts debounce
                    w_state = w_hit ? DEBOUNCE : IDLE;
                    w_cand  = w_hit ? w_idx : r_cand;
                    w_cnt   = w_hit ? CNT_W'(1) : '0;
                    w_tmr   = '0;
                    w_dir   = '0;
                end else if (w_expire) begin
                    w_state = REPEAT;
                    w_tmr   = '0;
                    w_pulse = r_dir;
                end else begin
                    w_tmr   = r_tmr == TMR_TOP ? r_tmr : r_tmr + TMR_W'(1);
                end
            endcase
            if (w_state == DEBOUNCE && w_cnt == CNT_END) begin
                w_state = HELD;
                w_tmr   = '0;
                w_dir   = N_ZONES'(1) << w_cand;
                w_pulse = N_ZONES'(1) << w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_dir   <= '0;
            r_pulse <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cand  <= w_cand;
            r_cnt   <= w_cnt;
            r_tmr   <= w_tmr;
            r_dir   <= w_dir;
            r_pulse <= w_pulse;
            r_busy  <= w_state != IDLE;
        end
    end

    assign dir       = r_dir;
    assign dir_pulse = r_pulse;
    assign busy      = r_busy;

endmodule

// File: tb/tb_touch_dir_decoder.sv
// tb_touch_dir_decoder: directed scenarios plus random touch traffic against a streak/elapsed-time model.
module tb_touch_dir_decoder;
    import touch_pkg::*;

    localparam int DEB = 3;
    localparam int DLY = 20;
    localparam int PER = 5;

    logic        clk = 0, rst_n = 0, pen_down = 0, sample_vld = 0;
    logic [7:0]  x_in = 0, y_in = 0;
    logic [31:0] zone_xlo = ZONE_XLO, zone_xhi = ZONE_XHI, zone_ylo = ZONE_YLO, zone_yhi = ZONE_YHI;
    logic [3:0]  dir, dir_pulse;
    logic        busy;

    int         n_chk = 0, n_bad = 0;
    int         m_cand = -1, m_streak = 0, m_since = 0, m_np = 0;
    bit         m_acc = 0;
    logic [3:0] e_pulse = 0;

    touch_dir_decoder #(.COORD_W(8), .N_ZONES(4), .DEBOUNCE_N(DEB), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
        .clk(clk), .rst_n(rst_n), .pen_down(pen_down), .sample_vld(sample_vld),
        .x_in(x_in), .y_in(y_in),
        .zone_xlo(zone_xlo), .zone_xhi(zone_xhi), .zone_ylo(zone_ylo), .zone_yhi(zone_yhi),
        .dir(dir), .dir_pulse(dir_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int zone_of(input int x, input int y);
        for (int i = 0; i < 4; i++)
            if (zone_xlo[i*8 +: 8] < x && x < zone_xhi[i*8 +: 8] && zone_ylo[i*8 +: 8] < y && y < zone_yhi[i*8 +: 8])
                return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cand = -1; m_streak = 0; m_since = 0; m_np = 0; e_pulse = 0;
    endtask

    // A zone is accepted once DEB consecutive samples agree; pulses come at accept, DLY later, then every PER.
    task automatic model(input bit pen, input bit vld, input int x, input int y);
        int z;
        z = zone_of(x, y);
        e_pulse = 0;
        if (!pen) model_reset();
        else if (vld && !(m_acc && z == m_cand)) begin
            if (z < 0) begin m_acc = 0; m_streak = 0; m_cand = -1; end
            else if (!m_acc && z == m_cand) m_streak++;
            else begin m_acc = 0; m_cand = z; m_streak = 1; end
            if (m_streak == DEB) begin m_acc = 1; m_since = 0; m_np = 1; e_pulse = 4'b1 << m_cand; end
        end else if (m_acc) begin
            m_since++;
            if (m_since == (m_np == 1 ? DLY : PER)) begin e_pulse = 4'b1 << m_cand; m_since = 0; m_np++; end
        end
    endtask

    task automatic step(input bit pen, input bit vld, input int x, input int y);
        pen_down = pen; sample_vld = vld; x_in = x[7:0]; y_in = y[7:0];
        @(posedge clk);
        model(pen, vld, x, y);
        #1;
        chk("dir", dir, m_acc ? 4'b1 << m_cand : 4'b0);
        chk("pulse", dir_pulse, e_pulse);
        chk("busy", busy, m_acc || m_streak > 0);
    endtask

    int px[8] = '{100, 230, 35, 100, 69, 142, 0, 120};
    int py[8] = '{20, 100, 100, 220, 20, 20, 0, 160};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dir", dir, 0); chk("rst_pulse", dir_pulse, 0); chk("rst_busy", busy, 0);
        rst_n = 1;

        step(1, 1, 100, 20); step(1, 0, 0, 0); step(1, 1, 100, 20); step(1, 1, 100, 20);
        chk("t1_dir", dir, 4'b0001); chk("t1_pulse", dir_pulse, 4'b0001);
        step(1, 0, 0, 0);
        chk("t1_hold", dir, 4'b0001); chk("t1_pulse_1clk", dir_pulse, 0);
        step(0, 0, 0, 0);

        step(1, 1, 100, 20);
        repeat (3) begin step(1, 1, 230, 100); chk("t2_no_z0", dir[0], 0); end
        chk("t2_dir", dir, 4'b0010); chk("t2_pulse", dir_pulse, 4'b0010);
        step(0, 0, 0, 0);

        repeat (3) step(1, 1, 100, 220);
        chk("t3_acc", dir_pulse, 4'b1000);
        for (int k = 1; k <= 30; k++) begin
            step(1, k % 7 == 0, 100, 220);
            chk("t3_pulse", dir_pulse, (k == 20 || k == 25 || k == 30) ? 4'b1000 : 4'b0);
            chk("t3_dir", dir, 4'b1000);
        end
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        #3 rst_n = 0;
        #1;
        chk("arst_dir", dir, 0); chk("arst_pulse", dir_pulse, 0); chk("arst_busy", busy, 0);
        model_reset();
        @(negedge clk) rst_n = 1;
        step(1, 1, 100, 20); step(1, 1, 100, 20);
        chk("arst_deb", dir, 0);
        step(1, 1, 100, 20);
        chk("arst_acc", dir, 4'b0001);

        repeat (19) step(1, 0, 0, 0);
        step(0, 1, 100, 20);
        chk("t4_pulse", dir_pulse, 0); chk("t4_dir", dir, 0); chk("t4_busy", busy, 0);

        repeat (3) step(1, 1, 100, 220);
        repeat (19) step(1, 0, 0, 0);
        step(1, 1, 230, 100);
        chk("chg_pulse", dir_pulse, 0); chk("chg_dir", dir, 0); chk("chg_busy", busy, 1);
        step(0, 0, 0, 0);

        step(1, 1, 69, 20);
        chk("edge_busy", busy, 0);
        zone_xlo[23:16] = 8'd90; zone_xhi[23:16] = 8'd110; zone_ylo[23:16] = 8'd10; zone_yhi[23:16] = 8'd30;
        repeat (3) step(1, 1, 100, 20);
        chk("ovl_dir", dir, 4'b0001);
        zone_xlo = ZONE_XLO; zone_xhi = ZONE_XHI; zone_ylo = ZONE_YLO; zone_yhi = ZONE_YHI;
        step(0, 0, 0, 0);

        for (int s = 0; s < 80; s++) begin
            int p, x, y, len;
            p = $urandom_range(0, 8);
            x = p < 8 ? px[p] : $urandom_range(0, 255);
            y = p < 8 ? py[p] : $urandom_range(0, 255);
            len = $urandom_range(5, 60);
            for (int c = 0; c < len; c++)
                step($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0, x, y);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
